// File: rtl/uart_autoflow.sv
// RTS/CTS hardware auto flow control: filters CTS, gates TX character starts on it,
// and drives RTS from RX FIFO water marks with hysteresis.
module uart_autoflow #(
    parameter int FifoDepth       = 16,
    parameter int RxHighWater     = 14,
    parameter int RxLowWater      = 8,
    parameter int CtsFilterCycles = 4,
    localparam int LW             = $clog2(FifoDepth) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          afe_en_i,
    input  logic          mcr_rts_i,
    input  logic          cts_i,
    input  logic [LW-1:0] rx_level_i,
    input  logic          tx_req_i,
    input  logic          tx_done_i,
    output logic          tx_grant_o,
    output logic          rts_o,
    output logic          cts_ok_o,
    output logic          tx_stalled_o
);

    localparam int CW = $clog2(CtsFilterCycles) + 1;
    localparam logic [CW-1:0] FilterLast = CW'(CtsFilterCycles - 1);
    localparam logic [LW-1:0] HighMark   = LW'(RxHighWater);
    localparam logic [LW-1:0] LowMark    = LW'(RxLowWater);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] filter_cnt;
    logic          thr, thr_next;
    logic          tx_go;

    // A CTS change is only accepted after it has held for CtsFilterCycles consecutive cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filter_cnt <= '0;
            cts_ok_o   <= 1'b0;
        end else if (cts_i == cts_ok_o) begin
            filter_cnt <= '0;
        end else if (filter_cnt == FilterLast) begin
            filter_cnt <= '0;
            cts_ok_o   <= cts_i;
        end else begin
            filter_cnt <= filter_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            thr          <= 1'b0;
            rts_o        <= 1'b0;
            tx_stalled_o <= 1'b0;
        end else begin
            state        <= state_next;
            thr          <= thr_next;
            rts_o        <= afe_en_i ? (mcr_rts_i & ~thr_next) : mcr_rts_i;
            tx_stalled_o <= (state == IDLE) & tx_req_i & afe_en_i & ~cts_ok_o;
        end
    end

    // Set wins over clear so a misconfigured pair of marks still throttles.
    always_comb begin
        thr_next = thr;
        if (rx_level_i >= HighMark) begin
            thr_next = 1'b1;
        end else if (rx_level_i <= LowMark) begin
            thr_next = 1'b0;
        end
    end

    // The grant is gated by rst_ni so that it also reads 0 while reset is asserted.
    always_comb begin
        state_next = state;
        tx_grant_o = 1'b0;
        tx_go      = tx_req_i & (cts_ok_o | ~afe_en_i);
        case (state)
            IDLE: begin
                if (tx_go) begin
                    tx_grant_o = rst_ni;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_done_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_autoflow.sv
// Self-checking bench for uart_autoflow: a queue/arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_autoflow;

    localparam int LW = 5;

    logic          clk_i;
    logic          rst_ni;
    logic          afe_en_i;
    logic          mcr_rts_i;
    logic          cts_i;
    logic [LW-1:0] rx_level_i;
    logic          tx_req_i;
    logic          tx_done_i;
    logic          tx_grant_o;
    logic          rts_o;
    logic          cts_ok_o;
    logic          tx_stalled_o;

    int checks = 0;
    int errors = 0;

    uart_autoflow #(
        .FifoDepth      (16),
        .RxHighWater    (14),
        .RxLowWater     (8),
        .CtsFilterCycles(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .afe_en_i    (afe_en_i),
        .mcr_rts_i   (mcr_rts_i),
        .cts_i       (cts_i),
        .rx_level_i  (rx_level_i),
        .tx_req_i    (tx_req_i),
        .tx_done_i   (tx_done_i),
        .tx_grant_o  (tx_grant_o),
        .rts_o       (rts_o),
        .cts_ok_o    (cts_ok_o),
        .tx_stalled_o(tx_stalled_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: CTS accepted once the last four samples all disagree with it,
    // at most one character outstanding, and RTS from hysteresis on the fill level.
    bit m_cts_ok, m_busy, m_stalled, m_thr, m_rts, m_go;
    bit hist[$];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist.delete();
            m_cts_ok  = 1'b0;
            m_busy    = 1'b0;
            m_stalled = 1'b0;
            m_thr     = 1'b0;
            m_rts     = 1'b0;
        end else begin
            m_go      = !m_busy && tx_req_i && (m_cts_ok || !afe_en_i);
            m_stalled = !m_busy && tx_req_i && afe_en_i && !m_cts_ok;
            if (m_go) m_busy = 1'b1;
            else if (m_busy && tx_done_i) m_busy = 1'b0;
            if (int'(rx_level_i) >= 14) m_thr = 1'b1;
            else if (int'(rx_level_i) <= 8) m_thr = 1'b0;
            m_rts = afe_en_i ? (mcr_rts_i && !m_thr) : mcr_rts_i;
            hist.push_back(cts_i);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] != m_cts_ok && hist[1] != m_cts_ok &&
                hist[2] != m_cts_ok && hist[3] != m_cts_ok)
                m_cts_ok = !m_cts_ok;
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            checkOutput("model_grant", tx_grant_o,
                        !m_busy && tx_req_i && (m_cts_ok || !afe_en_i));
            checkOutput("model_rts", rts_o, m_rts);
            checkOutput("model_cts_ok", cts_ok_o, m_cts_ok);
            checkOutput("model_stalled", tx_stalled_o, m_stalled);
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        afe_en_i   = 1'b0;
        mcr_rts_i  = 1'b0;
        cts_i      = 1'b0;
        rx_level_i = '0;
        tx_req_i   = 1'b0;
        tx_done_i  = 1'b0;
        #3;
        checkOutput("reset_grant", tx_grant_o, 1'b0);
        checkOutput("reset_rts", rts_o, 1'b0);
        checkOutput("reset_cts_ok", cts_ok_o, 1'b0);
        checkOutput("reset_stalled", tx_stalled_o, 1'b0);
        applyStimulus(2);
        rst_ni = 1'b1;
        applyStimulus(1);
        checkOutput("post_reset_cts_ok", cts_ok_o, 1'b0);

        // Bypass: CTS ignored, grant straight away, RTS follows SW bit
        mcr_rts_i = 1'b1;
        tx_req_i  = 1'b1;
        #1;
        checkOutput("bypass_grant", tx_grant_o, 1'b1);
        checkOutput("bypass_rts_before", rts_o, 1'b0);
        applyStimulus(1);
        checkOutput("bypass_rts_after", rts_o, 1'b1);
        checkOutput("bypass_no_regrant", tx_grant_o, 1'b0);
        applyStimulus(2);
        checkOutput("send_ignores_req", tx_grant_o, 1'b0);
        tx_done_i = 1'b1;
        tx_req_i  = 1'b0;
        applyStimulus(1);
        tx_done_i = 1'b0;

        // CTS glitch of 3 cycles never propagates
        afe_en_i = 1'b1;
        cts_i    = 1'b1;
        applyStimulus(3);
        checkOutput("glitch_cts_ok_hi", cts_ok_o, 1'b0);
        cts_i = 1'b0;
        applyStimulus(3);
        checkOutput("glitch_cts_ok_lo", cts_ok_o, 1'b0);

        // Steady CTS: accepted exactly 4 cycles after the rise
        cts_i = 1'b1;
        applyStimulus(3);
        checkOutput("cts_ok_3cyc", cts_ok_o, 1'b0);
        applyStimulus(1);
        checkOutput("cts_ok_4cyc", cts_ok_o, 1'b1);
        tx_req_i = 1'b1;
        #1;
        checkOutput("cts_grant", tx_grant_o, 1'b1);
        applyStimulus(1);

        // Flow stop: CTS lost mid-character
        cts_i    = 1'b0;
        tx_req_i = 1'b0;
        applyStimulus(2);
        checkOutput("flow_cts_ok_still", cts_ok_o, 1'b1);
        tx_done_i = 1'b1;
        applyStimulus(1);
        tx_done_i = 1'b0;
        applyStimulus(2);
        checkOutput("flow_cts_ok_lost", cts_ok_o, 1'b0);
        tx_req_i = 1'b1;
        #1;
        checkOutput("flow_blocked", tx_grant_o, 1'b0);
        applyStimulus(1);
        checkOutput("flow_stalled", tx_stalled_o, 1'b1);
        cts_i = 1'b1;
        applyStimulus(3);
        checkOutput("flow_wait_grant", tx_grant_o, 1'b0);
        applyStimulus(1);
        checkOutput("flow_resume_grant", tx_grant_o, 1'b1);
        applyStimulus(1);
        tx_req_i  = 1'b0;
        tx_done_i = 1'b1;
        applyStimulus(1);
        tx_done_i = 1'b0;

        // Water marks with hysteresis
        for (int l = 0; l < 14; l++) begin
            rx_level_i = LW'(l);
            applyStimulus(1);
        end
        checkOutput("wm_level13_rts", rts_o, 1'b1);
        rx_level_i = 5'd14;
        #1;
        checkOutput("wm_level14_before", rts_o, 1'b1);
        applyStimulus(1);
        checkOutput("wm_level14_rts", rts_o, 1'b0);
        rx_level_i = 5'd9;
        applyStimulus(1);
        checkOutput("wm_level9_rts", rts_o, 1'b0);
        rx_level_i = 5'd8;
        applyStimulus(1);
        checkOutput("wm_level8_rts", rts_o, 1'b1);
        rx_level_i = 5'd16;
        applyStimulus(1);
        checkOutput("wm_level16_rts", rts_o, 1'b0);
        afe_en_i = 1'b0;
        applyStimulus(1);
        checkOutput("wm_bypass_rts", rts_o, 1'b1);
        rx_level_i = 5'd10;
        afe_en_i   = 1'b1;
        applyStimulus(1);
        checkOutput("wm_thr_kept", rts_o, 1'b0);
        rx_level_i = 5'd0;
        applyStimulus(1);

        // Back-to-back characters with tx_req held
        tx_req_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("b2b_grant", tx_grant_o, 1'b1);
            applyStimulus(3);
            tx_done_i = 1'b1;
            #1;
            checkOutput("b2b_no_grant_on_done", tx_grant_o, 1'b0);
            applyStimulus(1);
            tx_done_i = 1'b0;
        end
        applyStimulus(1);

        // Reset mid-character clears everything asynchronously
        afe_en_i = 1'b0;
        rst_ni   = 1'b0;
        #2;
        checkOutput("async_grant", tx_grant_o, 1'b0);
        checkOutput("async_rts", rts_o, 1'b0);
        checkOutput("async_cts_ok", cts_ok_o, 1'b0);
        checkOutput("async_stalled", tx_stalled_o, 1'b0);
        applyStimulus(2);
        rst_ni = 1'b1;
        #1;
        checkOutput("post_reset_idle_grant", tx_grant_o, 1'b1);
        applyStimulus(3);
        tx_req_i  = 1'b0;
        tx_done_i = 1'b1;
        applyStimulus(1);
        tx_done_i = 1'b0;
        applyStimulus(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
